sprite_line_sched: RTL and testbench

SPRITE_LINE_SCHED -- requirements
Module: sprite_line_sched

---
 rtl/sprite_line_sched_pkg.sv | 33 +++
 rtl/sprite_line_sched.sv | 194 +++++++++++++++++++
 tb/tb_sprite_line_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_sched_pkg.sv
// Shared types and descriptor layout for the sprite line scheduler.
// Holds the FSM state enum, descriptor field positions and the visibility test.
package sprite_line_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_CHECK = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } sched_state_e;

   localparam int X_LSB     = 0;
   localparam int X_MSB     = 9;
   localparam int Y_LSB     = 10;
   localparam int Y_MSB     = 19;
   localparam int SHAPE_LSB = 20;
   localparam int SHAPE_MSB = 25;

   localparam logic [5:0] SHAPE_EMPTY = 6'd0;

   // Visible iff the slot is populated and the line falls inside [y, y+height); no vertical wrap.
   function automatic logic sprite_visible(input logic [31:0] desc,
                                           input logic [9:0]  line,
                                           input logic [10:0] height);
      logic [10:0] diff;
      diff = {1'b0, line} - {1'b0, desc[Y_MSB:Y_LSB]};
      return (desc[SHAPE_MSB:SHAPE_LSB] != SHAPE_EMPTY) &&
             (line >= desc[Y_MSB:Y_LSB]) &&
             (diff < height);
   endfunction

endpackage

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans descriptor slots and emits visible sprites in slot order.
// Define SPRITE_SCHED_OVF_EN to get a sticky overflow flag when sprites are dropped.
module sprite_line_sched
   import sprite_line_sched_pkg::*;
#(
   parameter int NUM_SLOTS    = 30,
   parameter int SPRITE_H     = 32,
   parameter int MAX_PER_LINE = 8
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        line_start,
   input  logic [9:0]                  next_line,
   output logic [4:0]                  desc_addr,
   input  logic [31:0]                 desc_data,
   output logic                        ent_valid,
   input  logic                        ent_ready,
   output logic [4:0]                  ent_slot,
   output logic [9:0]                  ent_x,
   output logic [$clog2(SPRITE_H)-1:0] ent_row,
   output logic [5:0]                  ent_shape,
   output logic                        line_done,
   output logic                        busy,
   output logic                        ovf
);

   localparam int ROW_W = $clog2(SPRITE_H);
   localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

   sched_state_e     state_q, state_d;
   logic [9:0]       line_q, line_d;
   logic [4:0]       slot_q, slot_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       desc_addr_q, desc_addr_d;
   logic             ent_valid_q, ent_valid_d;
   logic [4:0]       ent_slot_q, ent_slot_d;
   logic [9:0]       ent_x_q, ent_x_d;
   logic [ROW_W-1:0] ent_row_q, ent_row_d;
   logic [5:0]       ent_shape_q, ent_shape_d;
   logic             line_done_q, line_done_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;

   logic             last_slot_s;
   sched_state_e     adv_state_s;
   logic [4:0]       adv_slot_s;
   logic [10:0]      line_diff_s;
   logic             visible_s;
   logic             start_s;
   logic             room_s;
   logic             drop_s;
   logic             unused_s;

   // Where the scan goes after finishing the current slot.
   assign last_slot_s = (slot_q == 5'(NUM_SLOTS - 1));
   assign adv_state_s = last_slot_s ? ST_DONE : ST_FETCH;
   assign adv_slot_s  = last_slot_s ? slot_q : slot_q + 5'd1;

   assign line_diff_s = {1'b0, line_q} - {1'b0, desc_data[Y_MSB:Y_LSB]};
   assign visible_s   = sprite_visible(desc_data, line_q, 11'(SPRITE_H));
   assign start_s     = (state_q == ST_IDLE) && line_start;
   assign room_s      = (count_q < CNT_W'(MAX_PER_LINE));
   assign drop_s      = (state_q == ST_CHECK) && visible_s && !room_s;
   assign unused_s    = ^{desc_data[31:26], line_diff_s[10:ROW_W]};

   // Next-state and next-output logic of the scan FSM.
   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      slot_d      = slot_q;
      count_d     = count_q;
      desc_addr_d = desc_addr_q;
      ent_valid_d = ent_valid_q;
      ent_slot_d  = ent_slot_q;
      ent_x_d     = ent_x_q;
      ent_row_d   = ent_row_q;
      ent_shape_d = ent_shape_q;
      line_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d     = ST_FETCH;
               line_d      = next_line;
               slot_d      = 5'd0;
               count_d     = '0;
               desc_addr_d = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (visible_s && room_s) begin
               state_d     = ST_EMIT;
               ent_valid_d = 1'b1;
               ent_slot_d  = slot_q;
               ent_x_d     = desc_data[X_MSB:X_LSB];
               ent_row_d   = line_diff_s[ROW_W-1:0];
               ent_shape_d = desc_data[SHAPE_MSB:SHAPE_LSB];
            end else begin
               state_d     = adv_state_s;
               slot_d      = adv_slot_s;
               desc_addr_d = adv_slot_s;
            end
         end
         ST_EMIT: begin
            if (ent_ready) begin
               ent_valid_d = 1'b0;
               count_d     = count_q + CNT_W'(1);
               state_d     = adv_state_s;
               slot_d      = adv_slot_s;
               desc_addr_d = adv_slot_s;
            end else begin
               state_d = ST_EMIT;
            end
         end
         ST_DONE: begin
            line_done_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            ent_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Sticky overflow flag, cleared when a new scan is accepted.
   always_comb begin
`ifdef SPRITE_SCHED_OVF_EN
      if (start_s) begin
         ovf_d = 1'b0;
      end else if (drop_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
`else
      ovf_d = 1'b0;
`endif
   end

`ifndef SPRITE_SCHED_OVF_EN
   logic unused_drop_s;
   assign unused_drop_s = drop_s;
`endif

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         line_q      <= 10'd0;
         slot_q      <= 5'd0;
         count_q     <= '0;
         desc_addr_q <= 5'd0;
         ent_valid_q <= 1'b0;
         ent_slot_q  <= 5'd0;
         ent_x_q     <= 10'd0;
         ent_row_q   <= '0;
         ent_shape_q <= 6'd0;
         line_done_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         slot_q      <= slot_d;
         count_q     <= count_d;
         desc_addr_q <= desc_addr_d;
         ent_valid_q <= ent_valid_d;
         ent_slot_q  <= ent_slot_d;
         ent_x_q     <= ent_x_d;
         ent_row_q   <= ent_row_d;
         ent_shape_q <= ent_shape_d;
         line_done_q <= line_done_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign desc_addr = desc_addr_q;
   assign ent_valid = ent_valid_q;
   assign ent_slot  = ent_slot_q;
   assign ent_x     = ent_x_q;
   assign ent_row   = ent_row_q;
   assign ent_shape = ent_shape_q;
   assign line_done = line_done_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Randomized self-checking bench for sprite_line_sched against a slot-list reference model.
module tb_sprite_line_sched;

   logic        clk;
   logic        reset;
   logic        line_start;
   logic [9:0]  next_line;
   logic [4:0]  desc_addr;
   logic [31:0] desc_data;
   logic        ent_valid;
   logic        ent_ready;
   logic [4:0]  ent_slot;
   logic [9:0]  ent_x;
   logic [4:0]  ent_row;
   logic [5:0]  ent_shape;
   logic        line_done;
   logic        busy;
   logic        ovf;

   logic [31:0] mem [0:31];
   int          total;
   int          bad;

`ifdef SPRITE_SCHED_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   // Entry packing: {slot[25:21], x[20:11], row[10:6], shape[5:0]}
   logic [25:0] got_q [$];
   logic [25:0] exp_q [$];
   bit          exp_drop;
   int          done_cnt;
   int          done_at;
   logic        ovf_at_done;
   logic        busy_first;
   logic        ovf_first;
   int          stall_seen;
   int          stall_bad;
   bit          timeout;

   sprite_line_sched dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .next_line  (next_line),
      .desc_addr  (desc_addr),
      .desc_data  (desc_data),
      .ent_valid  (ent_valid),
      .ent_ready  (ent_ready),
      .ent_slot   (ent_slot),
      .ent_x      (ent_x),
      .ent_row    (ent_row),
      .ent_shape  (ent_shape),
      .line_done  (line_done),
      .busy       (busy),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Descriptor register file with one cycle read latency.
   always @(posedge clk) desc_data <= mem[desc_addr];

   function automatic logic [31:0] mk_desc(input int x, input int y, input int shape);
      return {6'd0, 6'(shape), 10'(y), 10'(x)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
   endtask

   // Reference: visible slots in ascending order, first 8 kept, rest dropped.
   task automatic build_expected(input int line);
      int vis;
      int x, y, sh;
      vis = 0;
      exp_q.delete();
      for (int s = 0; s < 30; s++) begin
         x  = int'(mem[s][9:0]);
         y  = int'(mem[s][19:10]);
         sh = int'(mem[s][25:20]);
         if (sh != 0 && line >= y && (line - y) < 32) begin
            vis++;
            if (vis <= 8) exp_q.push_back({5'(s), 10'(x), 5'(line - y), 6'(sh)});
         end
      end
      exp_drop = (vis > 8);
   endtask

   // mode 0: always ready, 1: random ready, 2: stall first entry 5 cycles then ready.
   task automatic run_scan(input int line, input int mode, input int repulse_at);
      int          c;
      int          stall_left;
      logic [25:0] held;
      bit          first_valid;
      got_q.delete();
      done_cnt = 0; done_at = -1; ovf_at_done = 1'b0;
      stall_seen = 0; stall_bad = 0; timeout = 1'b0;
      first_valid = 1'b1; stall_left = 0; held = '0;
      @(negedge clk);
      line_start = 1'b1;
      next_line  = 10'(line);
      @(negedge clk);
      line_start = 1'b0;
      next_line  = 10'($urandom);
      busy_first = busy;
      ovf_first  = ovf;
      c = 1;
      forever begin
         if (line_done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at     = c;
               ovf_at_done = ovf;
            end
         end
         if (ent_valid) begin
            if (mode == 2 && first_valid) begin
               first_valid = 1'b0;
               stall_left  = 5;
               held        = {ent_slot, ent_x, ent_row, ent_shape};
            end
            if (stall_left > 0) begin
               stall_seen++;
               if ({ent_slot, ent_x, ent_row, ent_shape} !== held) stall_bad++;
               stall_left--;
               ent_ready = 1'b0;
            end else begin
               ent_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
               if (ent_ready) got_q.push_back({ent_slot, ent_x, ent_row, ent_shape});
            end
         end else begin
            ent_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         line_start = (c == repulse_at);
         if (done_at >= 0 && c >= done_at + 4) break;
         if (c >= 3000) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
         c++;
      end
      line_start = 1'b0;
      ent_ready  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; line_start = 1'b0; next_line = 10'd0; ent_ready = 1'b0;
      clear_mem();
      repeat (2) @(negedge clk);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      @(negedge clk);
      total++; if (ent_valid !== 1'b0) begin bad++; $display("FAIL reset_ent_valid got=%0b exp=0", ent_valid); end
      total++; if (line_done !== 1'b0) begin bad++; $display("FAIL reset_line_done got=%0b exp=0", line_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
      total++; if (desc_addr !== 5'd0) begin bad++; $display("FAIL reset_desc_addr got=%0d exp=0", desc_addr); end
      total++; if ({ent_slot, ent_x, ent_row, ent_shape} !== 26'd0) begin
         bad++; $display("FAIL reset_payload got=%h exp=0", {ent_slot, ent_x, ent_row, ent_shape});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [25:0] g;
      clear_mem();
      mem[3] = mk_desc(50, 100, 2);
      run_scan(110, 0, 0);
      g = (got_q.size() > 0) ? got_q[0] : '1;
      total++; if (timeout) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
      total++; if (busy_first !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b exp=1", busy_first); end
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
      total++; if (g !== {5'd3, 10'd50, 5'd10, 6'd2}) begin
         bad++; $display("FAIL single_entry got=%h exp=%h", g, {5'd3, 10'd50, 5'd10, 6'd2});
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
      total++; if (done_at != 63) begin bad++; $display("FAIL single_latency got=%0d exp=63", done_at); end
   endtask

   task automatic test_rows();
      int          lines [4];
      int          cnts [4];
      logic [25:0] g;
      lines = '{99, 132, 131, 100};
      cnts  = '{0, 0, 1, 1};
      clear_mem();
      mem[3] = mk_desc(50, 100, 2);
      for (int i = 0; i < 4; i++) begin
         run_scan(lines[i], 1, 0);
         total++; if (got_q.size() != cnts[i]) begin
            bad++; $display("FAIL rows_count line=%0d got=%0d exp=%0d", lines[i], got_q.size(), cnts[i]);
         end
         if (cnts[i] == 1) begin
            g = (got_q.size() > 0) ? got_q[0] : '1;
            total++; if (g !== {5'd3, 10'd50, 5'(lines[i] - 100), 6'd2}) begin
               bad++; $display("FAIL rows_entry line=%0d got=%h exp=%h", lines[i], g, {5'd3, 10'd50, 5'(lines[i] - 100), 6'd2});
            end
         end
      end
   endtask

   task automatic test_overflow();
      int slots [30];
      int j, t;
      clear_mem();
      for (int i = 0; i < 30; i++) slots[i] = i;
      for (int i = 29; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = slots[i]; slots[i] = slots[j]; slots[j] = t;
      end
      for (int i = 0; i < 30; i++) begin
         if (i < 10) mem[slots[i]] = mk_desc($urandom_range(0, 1023), 200 - $urandom_range(0, 31), $urandom_range(1, 63));
         else if (i < 15) mem[slots[i]] = mk_desc($urandom_range(0, 1023), 201 + $urandom_range(0, 50), $urandom_range(1, 63));
      end
      build_expected(200);
      run_scan(200, 1, 0);
      total++; if (got_q.size() != 8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (ovf_at_done !== OVF_ON) begin bad++; $display("FAIL ovf_flag got=%0b exp=%0b", ovf_at_done, OVF_ON); end
      total++; if (ovf !== OVF_ON) begin bad++; $display("FAIL ovf_sticky got=%0b exp=%0b", ovf, OVF_ON); end
      run_scan(0, 0, 0);
      total++; if (ovf_first !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", ovf_first); end
   endtask

   task automatic test_stall();
      logic [25:0] g;
      clear_mem();
      mem[7] = mk_desc(123, 500, 9);
      run_scan(510, 2, 0);
      g = (got_q.size() > 0) ? got_q[0] : '1;
      total++; if (stall_seen != 5) begin bad++; $display("FAIL stall_valid_cycles got=%0d exp=5", stall_seen); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_payload_changes got=%0d exp=0", stall_bad); end
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL stall_transfers got=%0d exp=1", got_q.size()); end
      total++; if (g !== {5'd7, 10'd123, 5'd10, 6'd9}) begin
         bad++; $display("FAIL stall_entry got=%h exp=%h", g, {5'd7, 10'd123, 5'd10, 6'd9});
      end
   endtask

   task automatic test_repulse();
      logic [25:0] g;
      clear_mem();
      mem[0] = mk_desc(1, 0, 5);
      run_scan(3, 0, 20);
      g = (got_q.size() > 0) ? got_q[0] : '1;
      total++; if (done_cnt != 1) begin bad++; $display("FAIL repulse_done_cnt got=%0d exp=1", done_cnt); end
      total++; if (done_at != 63) begin bad++; $display("FAIL repulse_latency got=%0d exp=63", done_at); end
      total++; if (g !== {5'd0, 10'd1, 5'd3, 6'd5}) begin
         bad++; $display("FAIL repulse_entry got=%h exp=%h", g, {5'd0, 10'd1, 5'd3, 6'd5});
      end
   endtask

   task automatic test_empty();
      clear_mem();
      run_scan(200, 1, 0);
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_count got=%0d exp=0", got_q.size()); end
      total++; if (done_at != 62) begin bad++; $display("FAIL empty_latency got=%0d exp=62", done_at); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int line;
      int mode;
      for (int it = 0; it < 16; it++) begin
         clear_mem();
         line = $urandom_range(0, 1023);
         for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 3) != 0)
               mem[s] = mk_desc($urandom_range(0, 1023), (line + 1024 - $urandom_range(0, 45)) % 1024, $urandom_range(0, 63));
         end
         build_expected(line);
         mode = it % 2;
         run_scan(line, mode, 0);
         total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_entry%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
         end
         total++; if (ovf_at_done !== (OVF_ON & exp_drop)) begin
            bad++; $display("FAIL rand%0d_ovf got=%0b exp=%0b", it, ovf_at_done, OVF_ON & exp_drop);
         end
         total++; if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done_cnt got=%0d exp=1", it, done_cnt); end
         if (mode == 0) begin
            total++; if (done_at != 62 + exp_q.size()) begin
               bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, done_at, 62 + exp_q.size());
            end
         end
      end
   endtask

   task automatic test_reset_mid_emit();
      bit          found;
      int          pulses;
      logic [25:0] g;
      clear_mem();
      mem[5] = mk_desc(10, 20, 3);
      @(negedge clk);
      line_start = 1'b1;
      next_line  = 10'd25;
      @(negedge clk);
      line_start = 1'b0;
      ent_ready  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (ent_valid) found = 1'b1;
         else @(negedge clk);
      end
      total++; if (!found) begin bad++; $display("FAIL rst_emit_reached got=0 exp=1"); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (ent_valid !== 1'b0) begin bad++; $display("FAIL rst_emit_valid got=%0b exp=0", ent_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_emit_busy got=%0b exp=0", busy); end
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (line_done) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL rst_emit_line_done got=%0d exp=0", pulses); end
      run_scan(25, 0, 0);
      g = (got_q.size() > 0) ? got_q[0] : '1;
      total++; if (g !== {5'd5, 10'd10, 5'd5, 6'd3}) begin
         bad++; $display("FAIL rst_fresh_entry got=%h exp=%h", g, {5'd5, 10'd10, 5'd5, 6'd3});
      end
      total++; if (done_at != 63) begin bad++; $display("FAIL rst_fresh_latency got=%0d exp=63", done_at); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_rows();
      test_overflow();
      test_stall();
      test_repulse();
      test_empty();
      test_back_to_back();
      test_reset_mid_emit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
